// File: rtl/alu_sequencer_pkg.sv
// Shared types, operation codes and shift-type codes for the ALU command sequencer.
package alu_sequencer_pkg;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_ADD = 4'd0;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'd1;
  localparam logic [OP_BITS-1:0] OP_AND = 4'd2;
  localparam logic [OP_BITS-1:0] OP_OR  = 4'd3;
  localparam logic [OP_BITS-1:0] OP_XOR = 4'd4;
  localparam logic [OP_BITS-1:0] OP_MOV = 4'd5;

  localparam logic [1:0] SHIFT_ROR = 2'd0;
  localparam logic [1:0] SHIFT_SHR = 2'd1;
  localparam logic [1:0] SHIFT_SAR = 2'd2;

  typedef enum logic [1:0] {StIdle, StExec, StShift, StNop} state_e;

  // ALU cycles needed for one full pass over a single register or a register pair.
  function automatic int unsigned pass_beats(input logic pair, input int unsigned reg_bits,
                                             input int unsigned nshift);
    return (pair ? 2 : 1) * reg_bits / nshift;
  endfunction

endpackage

// File: rtl/alu_seq_cmd_reg.sv
// Latched command register; ALU_SEQ_SKID_EN adds a one-entry holding register so a
// command can be accepted while busy and started back-to-back.
module alu_seq_cmd_reg #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COUNT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_in,
  input  logic                  idle,
  input  logic                  done,
  output logic                  start,
  output logic [WIDTH-1:0]      cur,
  output logic                  next_shift,
  output logic [COUNT_BITS-1:0] next_count
);

  logic             accept;
  logic             skid_full;
  logic [WIDTH-1:0] next_cmd;
  logic [WIDTH-1:0] cur_q;

  assign accept = cmd_valid && cmd_ready;
  // A command starts when the sequencer is free (or freeing this cycle) and one is available.
  assign start  = (idle || done) && (accept || skid_full);

`ifdef ALU_SEQ_SKID_EN
  logic             full_q;
  logic [WIDTH-1:0] skid_q;

  assign skid_full = full_q;
  assign cmd_ready = !full_q;
  assign next_cmd  = full_q ? skid_q : cmd_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      skid_q <= '0;
    end else if (start) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
      skid_q <= cmd_in;
    end
  end
`else
  assign skid_full = 1'b0;
  assign cmd_ready = idle;
  assign next_cmd  = cmd_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q <= '0;
    end else if (start) begin
      cur_q <= next_cmd;
    end
  end

  assign cur        = cur_q;
  assign next_shift = next_cmd[WIDTH-1];
  assign next_count = next_cmd[WIDTH-2 -: COUNT_BITS];

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller driving the bit-serial ALU's op_valid/op_done protocol.
// Optional back-to-back command holding register enabled by ALU_SEQ_SKID_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned LOG2_NR    = 3,
  parameter int unsigned REG_BITS   = 8,
  parameter int unsigned NSHIFT     = 2,
  parameter int unsigned OP_BITS    = alu_sequencer_pkg::OP_BITS,
  parameter int unsigned COUNT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_shift,
  input  logic [OP_BITS-1:0]    cmd_op,
  input  logic [1:0]            cmd_shift_type,
  input  logic [LOG2_NR-1:0]    cmd_reg1,
  input  logic [LOG2_NR-1:0]    cmd_reg2,
  input  logic                  cmd_pair,
  input  logic [COUNT_BITS-1:0] cmd_count,
  input  logic                  cmd_flags,
  output logic                  alu_op_valid,
  input  logic                  alu_op_done,
  output logic [OP_BITS-1:0]    alu_operation,
  output logic [LOG2_NR-1:0]    alu_reg1,
  output logic [LOG2_NR-1:0]    alu_reg2,
  output logic                  alu_pair_op,
  output logic                  alu_update_reg1,
  output logic                  alu_rotate,
  output logic                  alu_do_ror1,
  output logic                  alu_last_ror1,
  output logic                  alu_do_shr,
  output logic                  alu_do_sar,
  output logic                  alu_update_carry_flags,
  output logic                  alu_update_other_flags,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned MAX_BEATS = 2 * REG_BITS / NSHIFT;
  localparam int unsigned BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned CMD_W     = 1 + COUNT_BITS + OP_BITS + 2 + 2 * LOG2_NR + 2;

  state_e                state_q;
  logic [COUNT_BITS-1:0] pass_q;
  logic [BEAT_W-1:0]     beat_q;

  logic                  start;
  logic                  idle;
  logic                  next_shift;
  logic [COUNT_BITS-1:0] next_count;
  logic [CMD_W-1:0]      cur;

  logic                  cur_shift;
  logic [COUNT_BITS-1:0] cur_count;
  logic [OP_BITS-1:0]    cur_op;
  logic [1:0]            cur_type;
  logic [LOG2_NR-1:0]    cur_reg1;
  logic [LOG2_NR-1:0]    cur_reg2;
  logic                  cur_pair;
  logic                  cur_flags;

  logic                  final_pass;
  logic [BEAT_W-1:0]     last_idx;

  assign idle = (state_q == StIdle);
  assign busy = !idle;

  // Shift flag and count sit at the top so the command register can decode the next state.
  alu_seq_cmd_reg #(
    .WIDTH      (CMD_W),
    .COUNT_BITS (COUNT_BITS)
  ) u_cmd_reg (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_in     ({cmd_shift, cmd_count, cmd_op, cmd_shift_type, cmd_reg1, cmd_reg2,
                  cmd_pair, cmd_flags}),
    .idle       (idle),
    .done       (done),
    .start      (start),
    .cur        (cur),
    .next_shift (next_shift),
    .next_count (next_count)
  );

  assign {cur_shift, cur_count, cur_op, cur_type, cur_reg1, cur_reg2, cur_pair, cur_flags} = cur;

  assign final_pass = (pass_q == cur_count - COUNT_BITS'(1));
  assign last_idx   = BEAT_W'(pass_beats(cur_pair, REG_BITS, NSHIFT) - 1);

  // pass_q counts completed ror1 passes; beat_q tracks the ALU cycle within the current pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pass_q  <= '0;
      beat_q  <= '0;
    end else if (start) begin
      state_q <= !next_shift ? StExec : ((next_count != '0) ? StShift : StNop);
      pass_q  <= '0;
      beat_q  <= '0;
    end else if (done) begin
      state_q <= StIdle;
      pass_q  <= '0;
      beat_q  <= '0;
    end else if (state_q == StShift) begin
      if (alu_op_done) begin
        pass_q <= pass_q + COUNT_BITS'(1);
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    alu_op_valid           = 1'b0;
    alu_operation          = '0;
    alu_reg1               = '0;
    alu_reg2               = '0;
    alu_pair_op            = 1'b0;
    alu_update_reg1        = 1'b0;
    alu_rotate             = 1'b0;
    alu_do_ror1            = 1'b0;
    alu_last_ror1          = 1'b0;
    alu_do_shr             = 1'b0;
    alu_do_sar             = 1'b0;
    alu_update_carry_flags = 1'b0;
    alu_update_other_flags = 1'b0;
    done                   = 1'b0;
    unique case (state_q)
      StExec: begin
        alu_op_valid           = 1'b1;
        alu_operation          = cur_op;
        alu_reg1               = cur_reg1;
        alu_reg2               = cur_reg2;
        alu_pair_op            = cur_pair;
        alu_update_reg1        = 1'b1;
        alu_update_carry_flags = cur_flags;
        alu_update_other_flags = cur_flags;
        done                   = alu_op_done;
      end
      StShift: begin
        if (cur_shift) begin
          alu_op_valid           = 1'b1;
          alu_reg1               = cur_reg1;
          alu_reg2               = cur_reg1;
          alu_pair_op            = cur_pair;
          alu_rotate             = 1'b1;
          alu_do_ror1            = 1'b1;
          alu_last_ror1          = (beat_q == last_idx);
          alu_do_shr             = (cur_type == SHIFT_SHR);
          alu_do_sar             = (cur_type == SHIFT_SAR);
          alu_update_carry_flags = cur_flags && final_pass;
          alu_update_other_flags = cur_flags && final_pass;
          done                   = alu_op_done && final_pass;
        end
      end
      StNop: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer with a command-level reference model and a small ALU
// stand-in; honours ALU_SEQ_SKID_EN for the expected back-to-back behaviour.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int unsigned LOG2_NR    = 3;
  localparam int unsigned REG_BITS   = 8;
  localparam int unsigned NSHIFT     = 2;
  localparam int unsigned OPB        = 4;
  localparam int unsigned COUNT_BITS = 4;
  localparam int          PB         = REG_BITS / NSHIFT;
`ifdef ALU_SEQ_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int TV = 4, TD = 3, TL = 2, TF = 1, TB = 0;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_shift, cmd_pair, cmd_flags;
  logic [OPB-1:0] cmd_op;
  logic [1:0] cmd_shift_type;
  logic [LOG2_NR-1:0] cmd_reg1, cmd_reg2;
  logic [COUNT_BITS-1:0] cmd_count;
  logic alu_op_valid, alu_op_done, alu_pair_op, alu_update_reg1, alu_rotate, alu_do_ror1;
  logic alu_last_ror1, alu_do_shr, alu_do_sar, alu_update_carry_flags, alu_update_other_flags;
  logic [OPB-1:0] alu_operation;
  logic [LOG2_NR-1:0] alu_reg1, alu_reg2;
  logic done, busy;
  logic spur;

  always #5 clk = ~clk;

  alu_sequencer #(
    .LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT), .OP_BITS(OPB),
    .COUNT_BITS(COUNT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shift(cmd_shift), .cmd_op(cmd_op), .cmd_shift_type(cmd_shift_type),
    .cmd_reg1(cmd_reg1), .cmd_reg2(cmd_reg2), .cmd_pair(cmd_pair), .cmd_count(cmd_count),
    .cmd_flags(cmd_flags), .alu_op_valid(alu_op_valid), .alu_op_done(alu_op_done),
    .alu_operation(alu_operation), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_pair_op(alu_pair_op), .alu_update_reg1(alu_update_reg1), .alu_rotate(alu_rotate),
    .alu_do_ror1(alu_do_ror1), .alu_last_ror1(alu_last_ror1), .alu_do_shr(alu_do_shr),
    .alu_do_sar(alu_do_sar), .alu_update_carry_flags(alu_update_carry_flags),
    .alu_update_other_flags(alu_update_other_flags), .done(done), .busy(busy)
  );

  // ALU stand-in: op_done on the last cycle of each pass; stray op_done pulses when idle.
  int alu_beat;
  always @(posedge clk or posedge reset) begin
    if (reset) alu_beat <= 0;
    else if (!alu_op_valid || alu_op_done) alu_beat <= 0;
    else alu_beat <= alu_beat + 1;
  end
  assign alu_op_done = alu_op_valid ? (alu_beat == (alu_pair_op ? 2 * PB : PB) - 1) : spur;

  typedef struct {
    bit shift; int op; int typ; int r1; int r2; bit pair; int count; bit flags;
  } cmd_s;

  typedef struct packed {
    logic valid; logic [OPB-1:0] op; logic [LOG2_NR-1:0] r1; logic [LOG2_NR-1:0] r2;
    logic pair, upd, rot, ror1, last, shr, sar, cf, of, done, busy, ready;
  } obs_t;

  cmd_s q[$];
  int   prog;
  int   total = 0;
  int   bad = 0;
  bit   rec = 0;
  logic [4:0] tr[$];

  function automatic cmd_s mk(bit s, int op, int typ, int r1, int r2, bit pair, int cnt,
                              bit fl);
    cmd_s c;
    c.shift = s; c.op = op; c.typ = typ; c.r1 = r1; c.r2 = r2;
    c.pair = pair; c.count = cnt; c.flags = fl;
    return c;
  endfunction

  function automatic int cmd_len(cmd_s c);
    int p;
    p = (c.pair ? 2 : 1) * PB;
    if (!c.shift) return p;
    if (c.count == 0) return 1;
    return c.count * p;
  endfunction

  // Expected outputs for the current cycle, from the command at the head of the queue.
  function automatic obs_t expect_now();
    obs_t e;
    cmd_s c;
    int   p;
    e = '0;
    e.ready = SKID ? (q.size() < 2) : (q.size() == 0);
    if (q.size() > 0) begin
      c = q[0];
      p = (c.pair ? 2 : 1) * PB;
      e.busy = 1'b1;
      if (!c.shift) begin
        e.valid = 1'b1; e.op = OPB'(c.op); e.r1 = LOG2_NR'(c.r1); e.r2 = LOG2_NR'(c.r2);
        e.pair = c.pair; e.upd = 1'b1; e.cf = c.flags; e.of = c.flags;
        e.done = (prog == p - 1);
      end else if (c.count == 0) begin
        e.done = 1'b1;
      end else begin
        e.valid = 1'b1; e.r1 = LOG2_NR'(c.r1); e.r2 = LOG2_NR'(c.r1); e.pair = c.pair;
        e.rot = 1'b1; e.ror1 = 1'b1; e.last = ((prog % p) == p - 1);
        e.shr = (c.typ == 1); e.sar = (c.typ == 2);
        e.cf = c.flags && (prog >= (c.count - 1) * p); e.of = e.cf;
        e.done = (prog == c.count * p - 1);
      end
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.valid = alu_op_valid; a.op = alu_operation; a.r1 = alu_reg1; a.r2 = alu_reg2;
    a.pair = alu_pair_op; a.upd = alu_update_reg1; a.rot = alu_rotate; a.ror1 = alu_do_ror1;
    a.last = alu_last_ror1; a.shr = alu_do_shr; a.sar = alu_do_sar;
    a.cf = alu_update_carry_flags; a.of = alu_update_other_flags; a.done = done;
    a.busy = busy; a.ready = cmd_ready;
    return a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic int count_bit(int b);
    int k = 0;
    for (int i = 0; i < tr.size(); i++) if (tr[i][b]) k++;
    return k;
  endfunction

  function automatic int nth_idx(int b, int n);
    int k = 0;
    int r = -1;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i][b]) begin
        k++;
        if (k == n && r < 0) r = i;
      end
    end
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model at posedge.
  task automatic tick(input bit v, input cmd_s c, output bit acc);
    obs_t e, a;
    cmd_valid = v; cmd_shift = c.shift; cmd_op = OPB'(c.op); cmd_shift_type = 2'(c.typ);
    cmd_reg1 = LOG2_NR'(c.r1); cmd_reg2 = LOG2_NR'(c.r2); cmd_pair = c.pair;
    cmd_count = COUNT_BITS'(c.count); cmd_flags = c.flags;
    spur = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    e = expect_now();
    a = sample();
    check("cycle", 32'(a), 32'(e));
    if (rec) tr.push_back({a.valid, a.done, a.last, a.cf, a.busy});
    acc = v && e.ready;
    @(posedge clk);
    if (!reset) begin
      if (q.size() > 0) begin
        if (prog == cmd_len(q[0]) - 1) begin
          void'(q.pop_front());
          prog = 0;
        end else begin
          prog++;
        end
      end
      if (acc) q.push_back(c);
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    cmd_s z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick(1'b0, z, acc);
  endtask

  task automatic issue(input cmd_s c);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 200) begin
      tick(1'b1, c, acc);
      n++;
    end
    check("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    q.delete();
    prog = 0;
    #2;
    check("rst_valid", 32'(alu_op_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    cmd_s c;
    bit   acc;
    reset = 1'b1; cmd_valid = 1'b0; spur = 1'b0; prog = 0;
    cmd_shift = 0; cmd_op = '0; cmd_shift_type = '0; cmd_reg1 = '0; cmd_reg2 = '0;
    cmd_pair = 0; cmd_count = '0; cmd_flags = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_valid", 32'(alu_op_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle(2);

    // Plain single op: 4 active cycles starting one after accept, done on the 4th.
    rec = 1; tr.delete();
    issue(mk(0, int'(OP_ADD), 0, 2, 3, 0, 0, 1));
    idle(8);
    check("add_valid_cnt", 32'(count_bit(TV)), 32'd4);
    check("add_first_valid", 32'(nth_idx(TV, 1)), 32'd1);
    check("add_done_idx", 32'(nth_idx(TD, 1)), 32'd4);
    check("add_done_cnt", 32'(count_bit(TD)), 32'd1);

    // Pair op: 8 active cycles, busy for 8.
    tr.delete();
    issue(mk(0, int'(OP_SUB), 0, 4, 5, 1, 0, 0));
    idle(12);
    check("sub_valid_cnt", 32'(count_bit(TV)), 32'd8);
    check("sub_busy_cnt", 32'(count_bit(TB)), 32'd8);
    check("sub_done_idx", 32'(nth_idx(TD, 1)), 32'd8);

    // Pair ror by 3: 24 active cycles, last_ror1 at 8/16/24, flags only in 17..24.
    tr.delete();
    issue(mk(1, 0, int'(SHIFT_ROR), 6, 1, 1, 3, 1));
    idle(28);
    check("ror_valid_cnt", 32'(count_bit(TV)), 32'd24);
    check("ror_last1", 32'(nth_idx(TL, 1)), 32'd8);
    check("ror_last2", 32'(nth_idx(TL, 2)), 32'd16);
    check("ror_last3", 32'(nth_idx(TL, 3)), 32'd24);
    check("ror_last_cnt", 32'(count_bit(TL)), 32'd3);
    check("ror_flag_first", 32'(nth_idx(TF, 1)), 32'd17);
    check("ror_flag_cnt", 32'(count_bit(TF)), 32'd8);
    check("ror_done_idx", 32'(nth_idx(TD, 1)), 32'd24);

    // Zero-count shift: single NOP cycle.
    tr.delete();
    issue(mk(1, 0, 1, 3, 0, 0, 0, 1));
    idle(4);
    check("nop_valid_cnt", 32'(count_bit(TV)), 32'd0);
    check("nop_done_cnt", 32'(count_bit(TD)), 32'd1);
    check("nop_done_idx", 32'(nth_idx(TD, 1)), 32'd1);

    // Reset during cycle 2 of a pair op.
    tr.delete();
    issue(mk(0, int'(OP_SUB), 0, 1, 2, 1, 0, 0));
    idle(1);
    mid_reset();
    idle(3);

    // Back-to-back single ops.
    tr.delete();
    issue(mk(0, int'(OP_ADD), 0, 1, 2, 0, 0, 0));
    issue(mk(0, int'(OP_XOR), 0, 3, 4, 0, 0, 1));
    idle(14);
    check("b2b_valid_cnt", 32'(count_bit(TV)), 32'd8);
    check("b2b_span", 32'(nth_idx(TV, 8) - nth_idx(TV, 1) + 1), SKID ? 32'd8 : 32'd9);
    check("b2b_done_gap", 32'(nth_idx(TD, 2) - nth_idx(TD, 1)), SKID ? 32'd4 : 32'd5);
    rec = 0;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      c = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 4), $urandom_range(0, 1));
      if ($urandom_range(0, 300) == 0) mid_reset();
      else tick($urandom_range(0, 2) != 0, c, acc);
    end
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
